// File: rtl/stream_consumer_if.sv
// Handshake bundle between the upstream producer, the stream_consumer buffer and its downstream reader.
interface stream_consumer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]      i_Input_Data;
    logic                       i_Data_Valid;
    logic                       o_Input_Ready;
    logic [DATA_WIDTH-1:0]      o_Output_Data;
    logic                       o_Data_Valid;
    logic                       i_Output_Ready;
    logic [$clog2(DEPTH):0]     o_Fill_Level;
    logic [COUNT_WIDTH-1:0]     o_Word_Count;

    // Buffer side
    modport slave (
        input  i_Input_Data, i_Data_Valid, i_Output_Ready,
        output o_Input_Ready, o_Output_Data, o_Data_Valid, o_Fill_Level, o_Word_Count
    );

    // Producer/reader side
    modport master (
        output i_Input_Data, i_Data_Valid, i_Output_Ready,
        input  o_Input_Ready, o_Output_Data, o_Data_Valid, o_Fill_Level, o_Word_Count
    );
endinterface

// File: rtl/stream_consumer.sv
// First-word-fall-through receive buffer with backpressure, occupancy report and accepted-word counter.
module stream_consumer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    stream_consumer_if.slave   bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [FILL_W-1:0]      fill_reg;
    logic [FILL_W-1:0]      fill_next;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // Ready depends only on the fill register, so a full buffer never passes a word through.
    assign in_ready  = (fill_reg != FILL_W'(DEPTH));
    assign out_valid = (fill_reg != '0);
    assign push      = bus.i_Data_Valid && in_ready;
    assign pop       = out_valid && bus.i_Output_Ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= bus.i_Input_Data;
                end
            end
        end
    endgenerate

    always_comb begin
        fill_next = fill_reg;
        case ({push, pop})
            2'b10:   fill_next = fill_reg + FILL_W'(1);
            2'b01:   fill_next = fill_reg - FILL_W'(1);
            default: fill_next = fill_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                count_reg  <= count_reg + COUNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            fill_reg <= fill_next;
        end
    end

    assign bus.o_Input_Ready = in_ready;
    assign bus.o_Data_Valid  = out_valid;
    assign bus.o_Output_Data = out_valid ? mem[rd_ptr_reg] : '0;
    assign bus.o_Fill_Level  = fill_reg;
    assign bus.o_Word_Count  = count_reg;
endmodule

// File: tb/tb_stream_consumer.sv
// Scoreboard bench for stream_consumer: a reference FIFO model predicts every output each cycle.
module tb_stream_consumer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stream_consumer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) bus ();

    stream_consumer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] sb[$];
    int m_fill  = 0;
    int m_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] head;
        head = (sb.size() != 0) ? sb[0] : '0;
        check_val({tag, "_fill"},  32'(bus.o_Fill_Level),  32'(m_fill));
        check_val({tag, "_count"}, 32'(bus.o_Word_Count),  32'(m_count));
        check_val({tag, "_valid"}, 32'(bus.o_Data_Valid),  32'(m_fill != 0));
        check_val({tag, "_ready"}, 32'(bus.o_Input_Ready), 32'(m_fill != DEPTH));
        check_val({tag, "_data"},  32'(bus.o_Output_Data), 32'(head));
    endtask

    // One clock: drive inputs, predict the handshakes from the model, then check after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic rst,
                         input string tag);
        bit push;
        bit pop;
        reset               = rst;
        bus.i_Data_Valid    = v;
        bus.i_Input_Data    = d;
        bus.i_Output_Ready  = r;
        push = !rst && v && (m_fill != DEPTH);
        pop  = !rst && r && (m_fill != 0);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_fill  = 0;
            m_count = 0;
        end else begin
            if (pop) begin
                $display("[%0t] %s pop  0x%02h", $time, tag, sb[0]);
                void'(sb.pop_front());
            end
            if (push) begin
                $display("[%0t] %s push 0x%02h", $time, tag, d);
                sb.push_back(d);
            end
            m_fill  = m_fill + int'(push) - int'(pop);
            m_count = (m_count + int'(push)) % (1 << CW);
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        reset              = 1'b1;
        bus.i_Data_Valid   = 1'b0;
        bus.i_Input_Data   = '0;
        bus.i_Output_Ready = 1'b0;

        // Reset and idle
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, "rst");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "idle");
        check_val("idle_ready", 32'(bus.o_Input_Ready), 32'd1);
        check_val("idle_data",  32'(bus.o_Output_Data), 32'd0);

        // Single word
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, "single");
        check_val("single_data", 32'(bus.o_Output_Data), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
        check_val("single_empty", 32'(bus.o_Data_Valid), 32'd0);

        // Fill to full; 0x05 is held upstream until a slot frees
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        check_val("full_ready", 32'(bus.o_Input_Ready), 32'd0);
        repeat (2) cycle(1'b1, 8'h05, 1'b0, 1'b0, "hold");
        cycle(1'b1, 8'h05, 1'b1, 1'b0, "full_pop");
        cycle(1'b1, 8'h05, 1'b1, 1'b0, "refill");
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        check_val("fill_count", 32'(bus.o_Word_Count), 32'd6);

        // Simultaneous push/pop at fill=2, then at fill=4
        cycle(1'b1, 8'h10, 1'b0, 1'b0, "sim");
        cycle(1'b1, 8'h11, 1'b0, 1'b0, "sim");
        cycle(1'b1, 8'h12, 1'b1, 1'b0, "sim2");
        check_val("sim2_fill", 32'(bus.o_Fill_Level), 32'd2);
        cycle(1'b1, 8'h13, 1'b0, 1'b0, "sim");
        cycle(1'b1, 8'h14, 1'b0, 1'b0, "sim");
        cycle(1'b1, 8'h15, 1'b1, 1'b0, "sim4");
        check_val("sim4_fill", 32'(bus.o_Fill_Level), 32'd3);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");

        // Reset mid-stream alongside a push
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, "mid_rst");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_rst");
        check_val("post_rst_valid", 32'(bus.o_Data_Valid), 32'd0);

        // Counter wrap: 17 words with downstream always ready
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "wrap");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        check_val("wrap_count", 32'(bus.o_Word_Count), 32'd1);
        check_val("wrap_empty", 32'(bus.o_Fill_Level), 32'd0);
        check_val("sb_empty",   32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
